// File: rtl/mode_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mode_mux_pkg
//  Brief    : Shared types and constants for the frame-synchronous N-way
//             display mode mux: RGB444 pixel struct, keyboard ASCII codes,
//             and on-screen-display tile geometry (used with MODE_OSD_EN).
//  Revision : 1.0 - initial release
// ============================================================================
package mode_mux_pkg;

  // One pixel as delivered by each tracker/mixer pipeline.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Keyboard codes: '1' selects mode 0, '2' mode 1, ...; 'm' cycles.
  localparam logic [7:0] KEY_DIGIT1 = 8'h31;
  localparam logic [7:0] KEY_CYCLE  = 8'h6D;
  localparam logic [7:0] KEY_NONE   = 8'h00;

  // OSD tiles: one 4x4 square per mode, laid out left to right.
  localparam int OSD_X0    = 8;
  localparam int OSD_Y0    = 8;
  localparam int OSD_PITCH = 6;
  localparam int OSD_SIZE  = 4;

  localparam rgb444_t OSD_RGB_ACTIVE   = 12'hFFF;
  localparam rgb444_t OSD_RGB_IDLE     = 12'h444;
  localparam rgb444_t OSD_RGB_FALLBACK = 12'hF80;

endpackage
`default_nettype wire

// File: rtl/frame_sync_mode_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sync_mode_mux_if
//  Brief    : Pixel/keyboard/sync bundle between the mixer pipelines and the
//             mode mux. The slave modport is the mux; master is its driver.
//  Revision : 1.0 - initial release
// ============================================================================
interface frame_sync_mode_mux_if #(
  parameter int N_MODES = 4
) ();
  import mode_mux_pkg::*;

  localparam int MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;

  logic                      v_sync;
  logic [7:0]                keyboard_data;
  logic [9:0]                x_pixel;
  logic [9:0]                y_pixel;
  rgb444_t [N_MODES-1:0]     rgb_in;
  logic [N_MODES-1:0]        target_off_in;

  logic [3:0]                r_port;
  logic [3:0]                g_port;
  logic [3:0]                b_port;
  logic                      target_off;
  logic [MODE_W-1:0]         active_mode;
  logic                      mode_changed;
  logic                      fallback_active;

  modport slave (
    input  v_sync, keyboard_data, x_pixel, y_pixel, rgb_in, target_off_in,
    output r_port, g_port, b_port, target_off, active_mode, mode_changed,
           fallback_active
  );

  modport master (
    output v_sync, keyboard_data, x_pixel, y_pixel, rgb_in, target_off_in,
    input  r_port, g_port, b_port, target_off, active_mode, mode_changed,
           fallback_active
  );

endinterface
`default_nettype wire

// File: rtl/mode_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : mode_key_decoder
//  Brief    : Brings the quasi-static keyboard code into clk, accepts a code
//             once it is stable, non-zero and new, and decodes it into a
//             mode-select pulse (sel_valid/sel_idx). 8'h00 re-arms the
//             acceptance so the same key can be used again.
//  Revision : 1.0 - initial release
// ============================================================================
module mode_key_decoder
  import mode_mux_pkg::*;
#(
  parameter int         N_MODES   = 4,
  parameter int         MODE_W    = 2,
  parameter logic [7:0] CYCLE_KEY = KEY_CYCLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        keyboard_data,
  input  logic [MODE_W-1:0] base_idx,
  output logic              sel_valid,
  output logic [MODE_W-1:0] sel_idx
);

  localparam logic [7:0]        DIGIT_LAST = KEY_DIGIT1 + 8'(N_MODES - 1);
  localparam logic [MODE_W-1:0] LAST_IDX   = MODE_W'(N_MODES - 1);

  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [7:0] prev_q,  prev_d;
  logic [7:0] last_q,  last_d;
  logic       stable;
  logic       accept;

  // Synchroniser shift, stability/novelty detect and code decode.
  always_comb begin
    sync1_d   = keyboard_data;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    stable    = (sync2_q == prev_q);
    accept    = stable && (sync2_q != KEY_NONE) && (sync2_q != last_q);
    last_d    = last_q;
    sel_valid = 1'b0;
    sel_idx   = '0;

    if (stable && (sync2_q == KEY_NONE)) begin
      last_d = KEY_NONE;
    end else if (accept) begin
      last_d = sync2_q;
    end

    if (accept) begin
      if ((sync2_q >= KEY_DIGIT1) && (sync2_q <= DIGIT_LAST)) begin
        sel_valid = 1'b1;
        sel_idx   = MODE_W'(sync2_q - KEY_DIGIT1);
      end else if (sync2_q == CYCLE_KEY) begin
        sel_valid = 1'b1;
        sel_idx   = (base_idx == LAST_IDX) ? '0 : base_idx + MODE_W'(1);
      end
    end
  end

  // Key pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= KEY_NONE;
      sync2_q <= KEY_NONE;
      prev_q  <= KEY_NONE;
      last_q  <= KEY_NONE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_sync_mode_mux.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sync_mode_mux
//  Brief    : N-way display mode mux. Keyboard selections are held pending
//             and applied only at the v_sync falling edge (no mid-frame
//             tearing). A run of LOST_FRAMES target-lost frames forces
//             FALLBACK_MODE. Selected RGB444/target_off registered once.
//             Optional: define MODE_OSD_EN to draw per-mode status tiles.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_sync_mode_mux
  import mode_mux_pkg::*;
#(
  parameter int         N_MODES       = 4,
  parameter int         DEFAULT_MODE  = 0,
  parameter int         FALLBACK_MODE = 0,
  parameter int         LOST_FRAMES   = 30,
  parameter logic [7:0] CYCLE_KEY     = KEY_CYCLE
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_sync_mode_mux_if.slave bus
);

  localparam int MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int CNT_W  = $clog2(LOST_FRAMES + 2);

  localparam logic [MODE_W-1:0] DEFAULT_IDX  = MODE_W'(DEFAULT_MODE);
  localparam logic [MODE_W-1:0] FALLBACK_IDX = MODE_W'(FALLBACK_MODE);
  localparam logic [CNT_W-1:0]  LOST_LIMIT   = CNT_W'(LOST_FRAMES);

  logic              vs_q, vs_d;
  logic              vs_prev_q, vs_prev_d;
  logic [MODE_W-1:0] active_mode_q, active_mode_d;
  logic              pending_valid_q, pending_valid_d;
  logic [MODE_W-1:0] pending_idx_q, pending_idx_d;
  logic [CNT_W-1:0]  lost_cnt_q, lost_cnt_d;
  logic              fallback_q, fallback_d;
  logic              mode_changed_q, mode_changed_d;
  rgb444_t           pix_q, pix_d;
  logic              target_off_q, target_off_d;

  logic              boundary;
  logic              sel_lost;
  logic [CNT_W-1:0]  cnt_inc;
  logic              sel_valid;
  logic [MODE_W-1:0] sel_idx;
  logic [MODE_W-1:0] base_idx;

  // A cycle key advances from whatever will be shown next.
  assign base_idx = pending_valid_q ? pending_idx_q : active_mode_q;

  mode_key_decoder #(
    .N_MODES   (N_MODES),
    .MODE_W    (MODE_W),
    .CYCLE_KEY (CYCLE_KEY)
  ) u_key (
    .clk           (clk),
    .reset         (reset),
    .keyboard_data (bus.keyboard_data),
    .base_idx      (base_idx),
    .sel_valid     (sel_valid),
    .sel_idx       (sel_idx)
  );

  // Frame-boundary mode update: pending key first, then lost-target fallback.
  always_comb begin
    vs_d            = bus.v_sync;
    vs_prev_d       = vs_q;
    boundary        = vs_prev_q & ~vs_q;
    sel_lost        = bus.target_off_in[active_mode_q];
    cnt_inc         = (lost_cnt_q == LOST_LIMIT) ? lost_cnt_q
                                                 : lost_cnt_q + CNT_W'(1);
    active_mode_d   = active_mode_q;
    pending_valid_d = pending_valid_q;
    pending_idx_d   = pending_idx_q;
    lost_cnt_d      = lost_cnt_q;
    fallback_d      = fallback_q;
    mode_changed_d  = 1'b0;

    if (boundary) begin
      if (pending_valid_q) begin
        active_mode_d   = pending_idx_q;
        pending_valid_d = 1'b0;
        lost_cnt_d      = '0;
        fallback_d      = 1'b0;
      end else if ((LOST_FRAMES > 0) && sel_lost) begin
        lost_cnt_d = cnt_inc;
        if ((cnt_inc == LOST_LIMIT) && (active_mode_q != FALLBACK_IDX)) begin
          active_mode_d = FALLBACK_IDX;
          fallback_d    = 1'b1;
          lost_cnt_d    = '0;
        end
      end else if (!sel_lost) begin
        lost_cnt_d = '0;
      end
      mode_changed_d = (active_mode_d != active_mode_q);
    end

    // A key landing on the boundary cycle waits for the next frame.
    if (sel_valid) begin
      pending_valid_d = 1'b1;
      pending_idx_d   = sel_idx;
    end
  end

  // Pixel select (plus optional status tiles) using the current mode.
  always_comb begin
    pix_d        = bus.rgb_in[active_mode_q];
    target_off_d = bus.target_off_in[active_mode_q];
`ifdef MODE_OSD_EN
    for (int k = 0; k < N_MODES; k++) begin
      if ((int'(bus.x_pixel) >= OSD_X0 + OSD_PITCH * k) &&
          (int'(bus.x_pixel) <  OSD_X0 + OSD_PITCH * k + OSD_SIZE) &&
          (int'(bus.y_pixel) >= OSD_Y0) &&
          (int'(bus.y_pixel) <  OSD_Y0 + OSD_SIZE)) begin
        if (MODE_W'(k) == active_mode_q) begin
          pix_d = fallback_q ? OSD_RGB_FALLBACK : OSD_RGB_ACTIVE;
        end else begin
          pix_d = OSD_RGB_IDLE;
        end
      end
    end
`endif
  end

`ifndef MODE_OSD_EN
  logic unused_osd_coords;
  assign unused_osd_coords = ^{bus.x_pixel, bus.y_pixel};
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q            <= 1'b0;
      vs_prev_q       <= 1'b0;
      active_mode_q   <= DEFAULT_IDX;
      pending_valid_q <= 1'b0;
      pending_idx_q   <= '0;
      lost_cnt_q      <= '0;
      fallback_q      <= 1'b0;
      mode_changed_q  <= 1'b0;
      pix_q           <= '0;
      target_off_q    <= 1'b0;
    end else begin
      vs_q            <= vs_d;
      vs_prev_q       <= vs_prev_d;
      active_mode_q   <= active_mode_d;
      pending_valid_q <= pending_valid_d;
      pending_idx_q   <= pending_idx_d;
      lost_cnt_q      <= lost_cnt_d;
      fallback_q      <= fallback_d;
      mode_changed_q  <= mode_changed_d;
      pix_q           <= pix_d;
      target_off_q    <= target_off_d;
    end
  end

  assign bus.r_port          = pix_q.r;
  assign bus.g_port          = pix_q.g;
  assign bus.b_port          = pix_q.b;
  assign bus.target_off      = target_off_q;
  assign bus.active_mode     = active_mode_q;
  assign bus.mode_changed    = mode_changed_q;
  assign bus.fallback_active = fallback_q;

endmodule
`default_nettype wire
